// File: rtl/adc_scan_scheduler_if.sv
// Request/response channel between control logic and the ADC scan scheduler.
// The master issues priority conversion requests and receives every conversion result.
interface adc_scan_scheduler_if;
  logic       req_valid;
  logic [2:0] req_ch;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_prio;
  logic [2:0] rsp_ch;
  logic [9:0] rsp_data;

  modport master (
    output req_valid, req_ch,
    input  req_ready, rsp_valid, rsp_prio, rsp_ch, rsp_data
  );

  modport slave (
    input  req_valid, req_ch,
    output req_ready, rsp_valid, rsp_prio, rsp_ch, rsp_data
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// MCP3008 sequencer: round-robin scans enabled channels into a result bank and
// interleaves single-shot priority conversions, driving the ADC SPI pins directly.
module adc_scan_scheduler #(
  parameter int unsigned HALF_DIV = 25,
  parameter int unsigned CS_GAP   = 50
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                ch_enable,
  adc_scan_scheduler_if.slave       bus,
  output logic [79:0]               scan_data,
  output logic                      busy,
  output logic                      AD_CLK,
  output logic                      CS,
  output logic                      DIN,
  input  logic                      DOUT
);

  localparam int unsigned CNT_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic             alt;
  logic [2:0]       cur_ch;
  logic             cur_prio;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       per;
  logic [9:0]       shreg;
  logic             dout_meta;
  logic             dout_sync;

  logic             take_prio;
  logic             scan_hit;
  logic [2:0]       scan_ch;
  logic [2:0]       cand;
  logic             din_next;

  assign bus.req_ready = (state == IDLE);

  // Alternation flag yields to the scan only when the scan has something to do.
  assign take_prio = bus.req_valid && !(alt && (|ch_enable));

  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      cand = ptr + 3'(i);
      if (!scan_hit && ch_enable[cand]) begin
        scan_hit = 1'b1;
        scan_ch  = cand;
      end
    end
  end

  // Command bit to present for the period following the current one.
  always_comb begin
    case (per)
      5'd1:    din_next = 1'b1;
      5'd2:    din_next = cur_ch[2];
      5'd3:    din_next = cur_ch[1];
      5'd4:    din_next = cur_ch[0];
      default: din_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_meta <= 1'b0;
      dout_sync <= 1'b0;
    end else begin
      dout_meta <= DOUT;
      dout_sync <= dout_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 3'd7;
      alt           <= 1'b0;
      cur_ch        <= '0;
      cur_prio      <= 1'b0;
      cnt           <= '0;
      per           <= '0;
      shreg         <= '0;
      CS            <= 1'b1;
      AD_CLK        <= 1'b0;
      DIN           <= 1'b0;
      busy          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_prio  <= 1'b0;
      bus.rsp_ch    <= '0;
      bus.rsp_data  <= '0;
      scan_data     <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (take_prio || scan_hit) begin
            if (take_prio) begin
              cur_ch   <= bus.req_ch;
              cur_prio <= 1'b1;
              alt      <= 1'b1;
            end else begin
              cur_ch   <= scan_ch;
              cur_prio <= 1'b0;
              ptr      <= scan_ch;
              alt      <= 1'b0;
            end
            state <= SETUP;
            CS    <= 1'b0;
            DIN   <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            AD_CLK <= 1'b1;
            per    <= 5'd1;
            state  <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // Sample on the first cycle of each high phase; periods 8..17 carry B9..B0.
          if (AD_CLK && (cnt == '0) && (per >= 5'd8))
            shreg <= {shreg[8:0], dout_sync};
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (AD_CLK) begin
              AD_CLK <= 1'b0;
              DIN    <= din_next;
            end else if (per == 5'd17) begin
              state         <= DONE;
              CS            <= 1'b1;
              bus.rsp_valid <= 1'b1;
              bus.rsp_prio  <= cur_prio;
              bus.rsp_ch    <= cur_ch;
              bus.rsp_data  <= shreg;
              for (int unsigned i = 0; i < 8; i++)
                if (cur_ch == 3'(i)) scan_data[i*10 +: 10] <= shreg;
            end else begin
              AD_CLK <= 1'b1;
              per    <= per + 5'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= GAP;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: MCP3008 behavioural model on the SPI pins plus a
// channel-order/result-bank reference model, checked with immediate assertions.
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ch_enable = '0;
  logic [79:0] scan_data;
  logic        busy, AD_CLK, CS, DIN;
  logic        DOUT = 1'b0;

  adc_scan_scheduler_if bus ();

  adc_scan_scheduler #(.HALF_DIV(25), .CS_GAP(50)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_enable (ch_enable),
    .bus       (bus),
    .scan_data (scan_data),
    .busy      (busy),
    .AD_CLK    (AD_CLK),
    .CS        (CS),
    .DIN       (DIN),
    .DOUT      (DOUT)
  );

  always #10 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [9:0] adc_val [8];
  logic [9:0] bank    [8];

  // ADC model: decodes the command from DIN on SCLK rises, shifts the result out on falls.
  int         m_per = 0;
  logic       m_clk_q = 1'b0;
  logic [4:0] m_cmd = '0;
  logic [2:0] dec_ch = '0;
  logic [1:0] dec_hdr = '0;
  logic [9:0] m_word;

  always @(negedge clk) begin
    if (CS !== 1'b0) begin
      m_per = 0;
      DOUT  = 1'b0;
    end else if (AD_CLK === 1'b1 && m_clk_q === 1'b0) begin
      m_per = m_per + 1;
      if (m_per <= 5) m_cmd[5 - m_per] = DIN;
      if (m_per == 5) begin
        dec_ch  = m_cmd[2:0];
        dec_hdr = m_cmd[4:3];
      end
    end else if (AD_CLK === 1'b0 && m_clk_q === 1'b1 && m_per >= 7 && m_per <= 16) begin
      m_word = adc_val[dec_ch];
      DOUT   = m_word[16 - m_per];
    end
    m_clk_q = AD_CLK;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] pack_bank();
    logic [79:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*10 +: 10] = bank[i];
    return v;
  endfunction

  function automatic logic [2:0] next_scan(input logic [7:0] mask, input int last);
    for (int k = 1; k <= 8; k++)
      if (mask[(last + k) % 8]) return 3'((last + k) % 8);
    return 3'd0;
  endfunction

  task automatic randomize_adc();
    for (int i = 0; i < 8; i++) adc_val[i] = 10'($urandom);
  endtask

  task automatic do_reset(input logic [7:0] en, input logic rv, input logic [2:0] rc);
    @(negedge clk);
    rst_n = 1'b0;
    ch_enable = en;
    bus.req_valid = rv;
    bus.req_ch = rc;
    for (int i = 0; i < 3; i++) @(negedge clk);
    for (int i = 0; i < 8; i++) bank[i] = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Waits for the next response and checks it against the model; leaves the bench past DONE.
  task automatic do_frame(input string tag, input logic [2:0] ch, input logic prio);
    int unsigned w;
    w = 0;
    while (bus.rsp_valid !== 1'b1 && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "/seen"},  80'(bus.rsp_valid), 80'(1'b1));
    check({tag, "/ch"},    80'(bus.rsp_ch),    80'(ch));
    check({tag, "/prio"},  80'(bus.rsp_prio),  80'(prio));
    check({tag, "/data"},  80'(bus.rsp_data),  80'(adc_val[ch]));
    check({tag, "/cmdch"}, 80'(dec_ch),        80'(ch));
    check({tag, "/hdr"},   80'(dec_hdr),       80'(2'b11));
    check({tag, "/sclk"},  80'(m_per),         80'(17));
    check({tag, "/cs"},    80'(CS),            80'(1'b1));
    bank[ch] = adc_val[ch];
    check({tag, "/bank"},  scan_data,          pack_bank());
    @(posedge clk); #1;
  endtask

  initial begin
    int           last;
    logic [7:0]   mask;
    logic [2:0]   ch;
    int           n_cs, n_sclk, n_rsp, n_rdy;
    int unsigned  changes;
    logic [3:0]   snap;
    int unsigned  w;

    bus.req_valid = 1'b0;
    bus.req_ch    = '0;
    randomize_adc();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst/CS",        80'(CS),            80'(1'b1));
    check("rst/AD_CLK",    80'(AD_CLK),        80'(1'b0));
    check("rst/DIN",       80'(DIN),           80'(1'b0));
    check("rst/busy",      80'(busy),          80'(1'b0));
    check("rst/rsp_valid", 80'(bus.rsp_valid), 80'(1'b0));
    check("rst/rsp_prio",  80'(bus.rsp_prio),  80'(1'b0));
    check("rst/rsp_ch",    80'(bus.rsp_ch),    80'(3'd0));
    check("rst/rsp_data",  80'(bus.rsp_data),  80'(10'd0));
    check("rst/scan_data", scan_data,          80'd0);
    check("rst/req_ready", 80'(bus.req_ready), 80'(1'b1));

    // Scan of ch0 and ch5 with fixed ADC values
    adc_val[0] = 10'h155;
    adc_val[5] = 10'h2AA;
    do_reset(8'b0010_0001, 1'b0, 3'd0);
    do_frame("scan0a", 3'd0, 1'b0);
    do_frame("scan5a", 3'd5, 1'b0);
    do_frame("scan0b", 3'd0, 1'b0);
    do_frame("scan5b", 3'd5, 1'b0);
    check("scan/ch0slot", 80'(scan_data[9:0]),   80'(10'h155));
    check("scan/ch5slot", 80'(scan_data[59:50]), 80'(10'h2AA));

    // Random masks and values against the round-robin model
    for (int r = 0; r < 2; r++) begin
      randomize_adc();
      mask = 8'($urandom_range(1, 255));
      do_reset(mask, 1'b0, 3'd0);
      last = 7;
      for (int f = 0; f < 4; f++) begin
        ch = next_scan(mask, last);
        do_frame($sformatf("rand%0d_%0d", r, f), ch, 1'b0);
        last = int'(ch);
      end
    end

    // Nothing enabled, no request: pins stay quiet
    do_reset(8'h00, 1'b0, 3'd0);
    snap = {CS, AD_CLK, busy, bus.rsp_valid};
    changes = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if ({CS, AD_CLK, busy, bus.rsp_valid} !== snap) changes++;
    end
    check("idle/changes", 80'(changes), 80'd0);
    check("idle/pins",    80'(snap),    80'(4'b1000));

    // Single priority request: cycle-exact latencies
    randomize_adc();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_ch    = 3'd3;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_cs = 0; n_sclk = 0; n_rsp = 0; n_rdy = 0;
    check("tim/ready_low", 80'(bus.req_ready), 80'(1'b0));
    for (int n = 1; n <= 1200; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (n_cs == 0 && CS === 1'b0) n_cs = n;
      if (n_sclk == 0 && AD_CLK === 1'b1) n_sclk = n;
      if (n_rsp == 0 && bus.rsp_valid === 1'b1) begin
        n_rsp = n;
        check("tim/prio", 80'(bus.rsp_prio), 80'(1'b1));
        check("tim/ch",   80'(bus.rsp_ch),   80'(3'd3));
        check("tim/data", 80'(bus.rsp_data), 80'(adc_val[3]));
      end
      if (n_rsp != 0 && n_rdy == 0 && bus.req_ready === 1'b1) n_rdy = n;
    end
    check("tim/cs_fall",   80'(n_cs),   80'd1);
    check("tim/sclk_rise", 80'(n_sclk), 80'd26);
    check("tim/rsp_valid", 80'(n_rsp),  80'd876);
    check("tim/req_ready", 80'(n_rdy),  80'd927);

    // Held request alternates with the scan, which keeps its own order
    randomize_adc();
    do_reset(8'hFF, 1'b1, 3'd3);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) do_frame($sformatf("alt%0d", k), 3'd3, 1'b1);
      else            do_frame($sformatf("alt%0d", k), 3'((k - 1) / 2), 1'b0);
    end
    bus.req_valid = 1'b0;

    // Reset during SHIFT period 10
    randomize_adc();
    do_reset(8'h24, 1'b0, 3'd0);
    w = 0;
    while (m_per != 10 && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    check("mrst/reached", 80'(m_per), 80'd10);
    rst_n = 1'b0;
    #1;
    check("mrst/CS",     80'(CS),     80'(1'b1));
    check("mrst/AD_CLK", 80'(AD_CLK), 80'(1'b0));
    changes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) changes++;
    end
    check("mrst/no_rsp", 80'(changes),   80'd0);
    check("mrst/bank",   scan_data,      80'd0);
    for (int i = 0; i < 8; i++) bank[i] = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_frame("mrst/first", 3'd2, 1'b0);

    // Channel disabled while its frame is running
    randomize_adc();
    do_reset(8'h0B, 1'b0, 3'd0);
    do_frame("clr/ch0", 3'd0, 1'b0);
    w = 0;
    while (!(busy === 1'b1 && m_per >= 3) && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    check("clr/inframe", 80'(busy), 80'(1'b1));
    ch_enable = 8'h09;
    do_frame("clr/ch1", 3'd1, 1'b0);
    do_frame("clr/ch3", 3'd3, 1'b0);
    do_frame("clr/ch0b", 3'd0, 1'b0);
    do_frame("clr/ch3b", 3'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
